// File: rtl/o8_memctl.sv
// O8 CPU bus controller: decodes each request into on-chip RAM, the I/O page or unmapped space.
// Define O8_MEMCTL_TIMEOUT_EN to build the I/O acknowledge timeout.
module o8_memctl #(
    parameter int unsigned RAM_AW   = 12,
    parameter int unsigned RAM_WAIT = 0,
    parameter logic [7:0]  IO_PAGE  = 8'hFF,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    input  logic        rd_i,
    input  logic        wr_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [7:0]  io_addr_o,
    output logic [7:0]  io_data_o,
    input  logic [7:0]  io_data_i,
    output logic        io_rd_o,
    output logic        io_wr_o,
    input  logic        io_ack_i
);

    typedef enum logic [1:0] {IDLE, RWAIT, IO, RESP} state_t;

    localparam logic [16:0] RAM_LIMIT = 17'(1 << RAM_AW);
    localparam logic [3:0]  WAIT_LOAD = 4'(RAM_WAIT);

    if (RAM_WAIT > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("o8_memctl: RAM_WAIT or TIMEOUT out of range");
    end

    logic [7:0] ram [2**RAM_AW];

    state_t      state, state_d;
    logic [3:0]  wait_cnt, wait_d;
    logic        ack_d, err_d;
    logic [7:0]  data_d;
    logic        io_rd_d, io_wr_d;
    logic [7:0]  io_addr_d, io_data_d;
    logic        ram_we;
    logic        req;
    logic [RAM_AW-1:0] ram_idx;

`ifdef O8_MEMCTL_TIMEOUT_EN
    localparam logic [7:0] TO_LOAD = 8'(TIMEOUT);
    logic [7:0] to_cnt, to_d;
`endif

    assign req     = rd_i | wr_i;
    assign ram_idx = addr_i[RAM_AW-1:0];

    always_comb begin
        state_d   = state;
        wait_d    = wait_cnt;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        data_d    = data_o;
        io_rd_d   = io_rd_o;
        io_wr_d   = io_wr_o;
        io_addr_d = io_addr_o;
        io_data_d = io_data_o;
        ram_we    = 1'b0;
`ifdef O8_MEMCTL_TIMEOUT_EN
        to_d      = to_cnt;
`endif
        case (state)
            IDLE: begin
                // The I/O page is checked before RAM so it wins if the regions overlap.
                if (req) begin
                    if (rd_i && wr_i) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        data_d  = '0;
                    end else if (addr_i[15:8] == IO_PAGE) begin
                        state_d   = IO;
                        io_rd_d   = rd_i;
                        io_wr_d   = wr_i;
                        io_addr_d = addr_i[7:0];
                        io_data_d = data_i;
`ifdef O8_MEMCTL_TIMEOUT_EN
                        to_d      = TO_LOAD;
`endif
                    end else if ({1'b0, addr_i} < RAM_LIMIT) begin
                        state_d = RWAIT;
                        wait_d  = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        data_d  = '0;
                    end
                end
            end
            RWAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (wait_cnt == 4'd0) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    if (rd_i) data_d = ram[ram_idx];
                    else      ram_we = 1'b1;
                end else begin
                    wait_d = wait_cnt - 4'd1;
                end
            end
            IO: begin
                // A withdrawn request drops the strobes silently; io_ack_i beats the timeout.
                if (!req) begin
                    state_d = IDLE;
                    io_rd_d = 1'b0;
                    io_wr_d = 1'b0;
                end else if (io_ack_i) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    io_rd_d = 1'b0;
                    io_wr_d = 1'b0;
                    if (io_rd_o) data_d = io_data_i;
`ifdef O8_MEMCTL_TIMEOUT_EN
                end else if (to_cnt == 8'd1) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    data_d  = '0;
                    io_rd_d = 1'b0;
                    io_wr_d = 1'b0;
                end else begin
                    to_d = to_cnt - 8'd1;
`endif
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            data_o    <= '0;
            io_rd_o   <= 1'b0;
            io_wr_o   <= 1'b0;
            io_addr_o <= '0;
            io_data_o <= '0;
`ifdef O8_MEMCTL_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_d;
            ack_o     <= ack_d;
            err_o     <= err_d;
            data_o    <= data_d;
            io_rd_o   <= io_rd_d;
            io_wr_o   <= io_wr_d;
            io_addr_o <= io_addr_d;
            io_data_o <= io_data_d;
`ifdef O8_MEMCTL_TIMEOUT_EN
            to_cnt    <= to_d;
`endif
        end
    end

    // RAM has no reset so it can map onto plain memory; contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (ram_we) ram[ram_idx] <= data_i;
    end

endmodule

// File: tb/tb_o8_memctl.sv
// Self-checking bench for o8_memctl: three instances (RAM_WAIT 0/3/5) checked against a
// behavioural model of the decode, latency and memory rules; timeout test follows O8_MEMCTL_TIMEOUT_EN.
module tb_o8_memctl;

    localparam int NDUT    = 3;
    localparam int TIMEOUT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NDUT-1:0][15:0] addr  = '0;
    logic [NDUT-1:0][7:0]  wdata = '0;
    logic [NDUT-1:0]       rd    = '0;
    logic [NDUT-1:0]       wr    = '0;
    logic [NDUT-1:0][7:0]  rdata;
    logic [NDUT-1:0]       ack;
    logic [NDUT-1:0]       err;
    logic [NDUT-1:0][7:0]  io_addr;
    logic [NDUT-1:0][7:0]  io_wdata;
    logic [NDUT-1:0]       io_rd;
    logic [NDUT-1:0]       io_wr;

    logic       io_ack0  = 1'b0;
    logic [7:0] io_val   = 8'h00;
    int         io_delay = 4;
    bit         io_en    = 1'b1;
    int         io_cnt   = 0;

    logic [7:0] mem   [NDUT][4096];
    bit         known [NDUT][4096];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    o8_memctl #(.RAM_AW(12), .RAM_WAIT(0), .IO_PAGE(8'hFF), .TIMEOUT(TIMEOUT)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .addr_i(addr[0]), .data_i(wdata[0]), .data_o(rdata[0]),
        .rd_i(rd[0]), .wr_i(wr[0]), .ack_o(ack[0]), .err_o(err[0]),
        .io_addr_o(io_addr[0]), .io_data_o(io_wdata[0]), .io_data_i(io_val),
        .io_rd_o(io_rd[0]), .io_wr_o(io_wr[0]), .io_ack_i(io_ack0));

    o8_memctl #(.RAM_AW(12), .RAM_WAIT(3), .IO_PAGE(8'hFF), .TIMEOUT(TIMEOUT)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .addr_i(addr[1]), .data_i(wdata[1]), .data_o(rdata[1]),
        .rd_i(rd[1]), .wr_i(wr[1]), .ack_o(ack[1]), .err_o(err[1]),
        .io_addr_o(io_addr[1]), .io_data_o(io_wdata[1]), .io_data_i(8'h00),
        .io_rd_o(io_rd[1]), .io_wr_o(io_wr[1]), .io_ack_i(1'b0));

    o8_memctl #(.RAM_AW(12), .RAM_WAIT(5), .IO_PAGE(8'hFF), .TIMEOUT(TIMEOUT)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .addr_i(addr[2]), .data_i(wdata[2]), .data_o(rdata[2]),
        .rd_i(rd[2]), .wr_i(wr[2]), .ack_o(ack[2]), .err_o(err[2]),
        .io_addr_o(io_addr[2]), .io_data_o(io_wdata[2]), .io_data_i(8'h00),
        .io_rd_o(io_rd[2]), .io_wr_o(io_wr[2]), .io_ack_i(1'b0));

    // I/O responder for dut0: acks on the io_delay-th falling edge that sees a strobe.
    always @(negedge clk) begin
        if (io_rd[0] || io_wr[0]) begin
            io_cnt  = io_cnt + 1;
            io_ack0 = io_en && (io_cnt >= io_delay);
        end else begin
            io_cnt  = 0;
            io_ack0 = 1'b0;
        end
    end

    function automatic int ram_wait(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 5;
    endfunction

    // Drives one request and reports when (edges counted from the sampling edge) a pulse appeared.
    task automatic bus_access(input int k, input bit r, input bit w, input logic [15:0] a,
                              input logic [7:0] d, output int lat, output bit got_ack,
                              output bit got_err, output logic [7:0] dout,
                              output bit strobe_ok, output bit single);
        lat = 0; got_ack = 1'b0; got_err = 1'b0; dout = 8'h00; strobe_ok = 1'b0; single = 1'b0;
        @(negedge clk);
        addr[k] = a; wdata[k] = d; rd[k] = r; wr[k] = w;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 1)
                strobe_ok = (io_addr[k] == a[7:0]) && (io_rd[k] == r) && (io_wr[k] == w) &&
                            (!w || io_wdata[k] == d);
            if (ack[k] || err[k]) begin
                lat = i; got_ack = ack[k]; got_err = err[k]; dout = rdata[k];
                break;
            end
        end
        rd[k] = 1'b0; wr[k] = 1'b0;
        if (lat == 0) begin
            checks++; errors++;
            $display("[TB] FAIL bus_bound dut%0d addr %h: no response within 60 edges", k, a);
        end
        @(posedge clk); #1;
        single = !ack[k] && !err[k];
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if ({ack[k], err[k], io_rd[k], io_wr[k], rdata[k], io_addr[k], io_wdata[k]} !== 28'h0) begin
                errors++;
                $display("[TB] FAIL reset_outputs dut%0d: got %h expected 0", k,
                         {ack[k], err[k], io_rd[k], io_wr[k], rdata[k], io_addr[k], io_wdata[k]});
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ram_round_trip();
        int lat; bit a_, e_, so, sg; logic [7:0] dout;
        bus_access(0, 1'b0, 1'b1, 16'h0123, 8'h5A, lat, a_, e_, dout, so, sg);
        mem[0][12'h123] = 8'h5A; known[0][12'h123] = 1'b1;
        checks++;
        if ({a_, e_, lat} !== {2'b10, 32'd2}) begin
            errors++; $display("[TB] FAIL ram_write_ack: got ack=%0b err=%0b lat=%0d expected ack lat=2", a_, e_, lat);
        end
        bus_access(0, 1'b1, 1'b0, 16'h0123, 8'h00, lat, a_, e_, dout, so, sg);
        checks++;
        if ({a_, e_, lat} !== {2'b10, 32'd2}) begin
            errors++; $display("[TB] FAIL ram_read_ack: got ack=%0b err=%0b lat=%0d expected ack lat=2", a_, e_, lat);
        end
        checks++;
        if (dout !== 8'h5A) begin
            errors++; $display("[TB] FAIL ram_read_data: got %h expected 5a", dout);
        end
        checks++;
        if (sg !== 1'b1) begin
            errors++; $display("[TB] FAIL ram_single_pulse: pulse lasted more than one cycle");
        end
    endtask

    task automatic test_wait_states();
        int lat; bit a_, e_, so, sg; logic [7:0] dout;
        bus_access(1, 1'b1, 1'b0, 16'h0000, 8'h00, lat, a_, e_, dout, so, sg);
        checks++;
        if ({a_, e_, lat} !== {2'b10, 32'd5}) begin
            errors++; $display("[TB] FAIL wait_read_lat: got ack=%0b err=%0b lat=%0d expected ack lat=5", a_, e_, lat);
        end
        bus_access(1, 1'b0, 1'b1, 16'h0FFF, 8'hA7, lat, a_, e_, dout, so, sg);
        mem[1][12'hFFF] = 8'hA7; known[1][12'hFFF] = 1'b1;
        bus_access(1, 1'b1, 1'b0, 16'h0FFF, 8'h00, lat, a_, e_, dout, so, sg);
        checks++;
        if ({a_, lat, dout} !== {1'b1, 32'd5, 8'hA7}) begin
            errors++; $display("[TB] FAIL wait_top_addr: got ack=%0b lat=%0d data=%h expected ack lat=5 data=a7", a_, lat, dout);
        end
    endtask

    task automatic test_io_read();
        int lat; bit a_, e_, so, sg; logic [7:0] dout;
        io_en = 1'b1; io_delay = 4; io_val = 8'hC3;
        bus_access(0, 1'b1, 1'b0, 16'hFF10, 8'h00, lat, a_, e_, dout, so, sg);
        checks++;
        if (so !== 1'b1) begin
            errors++; $display("[TB] FAIL io_strobe: strobe/address wrong, got io_addr=%h expected 10", io_addr[0]);
        end
        checks++;
        if ({a_, e_, lat, dout} !== {2'b10, 32'd5, 8'hC3}) begin
            errors++; $display("[TB] FAIL io_read: got ack=%0b err=%0b lat=%0d data=%h expected ack lat=5 data=c3", a_, e_, lat, dout);
        end
    endtask

    task automatic test_decode_errors();
        int lat; bit a_, e_, so, sg; logic [7:0] dout;
        bus_access(0, 1'b1, 1'b0, 16'h2000, 8'h00, lat, a_, e_, dout, so, sg);
        checks++;
        if ({a_, e_, lat, dout} !== {2'b01, 32'd1, 8'h00}) begin
            errors++; $display("[TB] FAIL unmapped_err: got ack=%0b err=%0b lat=%0d data=%h expected err lat=1 data=00", a_, e_, lat, dout);
        end
        bus_access(0, 1'b0, 1'b1, 16'h0000, 8'h21, lat, a_, e_, dout, so, sg);
        mem[0][0] = 8'h21; known[0][0] = 1'b1;
        bus_access(0, 1'b1, 1'b1, 16'h0000, 8'h77, lat, a_, e_, dout, so, sg);
        checks++;
        if ({a_, e_, lat} !== {2'b01, 32'd1}) begin
            errors++; $display("[TB] FAIL rdwr_err: got ack=%0b err=%0b lat=%0d expected err lat=1", a_, e_, lat);
        end
        bus_access(0, 1'b1, 1'b0, 16'h0000, 8'h00, lat, a_, e_, dout, so, sg);
        checks++;
        if (dout !== 8'h21) begin
            errors++; $display("[TB] FAIL rdwr_ram_kept: got %h expected 21", dout);
        end
    endtask

`ifdef O8_MEMCTL_TIMEOUT_EN
    task automatic test_timeout();
        int lat; bit a_, e_, so, sg; logic [7:0] dout;
        io_en = 1'b0;
        bus_access(0, 1'b0, 1'b1, 16'hFF00, 8'h3C, lat, a_, e_, dout, so, sg);
        checks++;
        if ({a_, e_, lat, dout} !== {2'b01, 32'(TIMEOUT + 1), 8'h00}) begin
            errors++; $display("[TB] FAIL io_timeout: got ack=%0b err=%0b lat=%0d data=%h expected err lat=%0d", a_, e_, lat, dout, TIMEOUT + 1);
        end
        checks++;
        if (io_wr[0] !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_strobe: got io_wr=%0b expected 0", io_wr[0]);
        end
        io_en = 1'b1;
    endtask
`else
    task automatic test_timeout();
        int pulses = 0;
        io_en = 1'b0;
        @(negedge clk);
        addr[0] = 16'hFF00; wdata[0] = 8'h3C; wr[0] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ack[0] || err[0]) pulses++;
        end
        checks++;
        if ({pulses, io_wr[0]} !== {32'd0, 1'b1}) begin
            errors++; $display("[TB] FAIL io_wait_forever: got pulses=%0d io_wr=%0b expected 0 and 1", pulses, io_wr[0]);
        end
        @(negedge clk);
        wr[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({io_wr[0], ack[0], err[0]} !== 3'b000) begin
            errors++; $display("[TB] FAIL io_abort: got io_wr/ack/err=%b expected 000", {io_wr[0], ack[0], err[0]});
        end
        io_en = 1'b1;
    endtask
`endif

    task automatic test_abort();
        int lat; bit a_, e_, so, sg; logic [7:0] dout; int pulses = 0;
        bus_access(2, 1'b0, 1'b1, 16'h0040, 8'h11, lat, a_, e_, dout, so, sg);
        mem[2][12'h040] = 8'h11; known[2][12'h040] = 1'b1;
        checks++;
        if ({a_, lat} !== {1'b1, 32'd7}) begin
            errors++; $display("[TB] FAIL wait5_write: got ack=%0b lat=%0d expected ack lat=7", a_, lat);
        end
        @(negedge clk);
        addr[2] = 16'h0040; wdata[2] = 8'hEE; wr[2] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        wr[2] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack[2] || err[2]) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("[TB] FAIL abort_no_pulse: got %0d pulses expected 0", pulses);
        end
        bus_access(2, 1'b1, 1'b0, 16'h0040, 8'h00, lat, a_, e_, dout, so, sg);
        checks++;
        if (dout !== 8'h11) begin
            errors++; $display("[TB] FAIL abort_ram_kept: got %h expected 11", dout);
        end
    endtask

    task automatic test_reset_mid_io();
        int lat; bit a_, e_, so, sg; logic [7:0] dout;
        io_en = 1'b0;
        @(negedge clk);
        addr[0] = 16'hFF20; rd[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({io_rd[0], io_addr[0]} !== {1'b1, 8'h20}) begin
            errors++; $display("[TB] FAIL mid_io_strobe: got io_rd=%0b io_addr=%h expected 1 and 20", io_rd[0], io_addr[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({io_rd[0], io_wr[0], ack[0], err[0], io_addr[0], rdata[0]} !== 20'h0) begin
            errors++; $display("[TB] FAIL async_reset: got %h expected 0", {io_rd[0], io_wr[0], ack[0], err[0], io_addr[0], rdata[0]});
        end
        rd[0] = 1'b0;
        io_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bus_access(0, 1'b1, 1'b0, 16'h0123, 8'h00, lat, a_, e_, dout, so, sg);
        checks++;
        if ({a_, lat, dout} !== {1'b1, 32'd2, mem[0][12'h123]}) begin
            errors++; $display("[TB] FAIL after_reset_read: got ack=%0b lat=%0d data=%h expected ack lat=2 data=%h", a_, lat, dout, mem[0][12'h123]);
        end
    endtask

    task automatic test_random();
        int lat; bit a_, e_, so, sg; logic [7:0] dout;
        int sel; bit r, w; logic [15:0] a; logic [7:0] d;
        bit exp_ack, is_io, check_data; int exp_lat; logic [7:0] exp_data;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 9));
            r = 1'($urandom_range(0, 1)); w = !r;
            d = 8'($urandom); io_val = 8'($urandom); io_delay = int'($urandom_range(1, 6));
            if (sel <= 5)      a = 16'h0800 + 16'($urandom_range(0, 15));
            else if (sel == 6) a = 16'($urandom_range(0, 16'h0FFF));
            else if (sel == 7) a = {8'hFF, 8'($urandom)};
            else if (sel == 8) a = 16'($urandom_range(16'h1000, 16'hFEFF));
            else begin a = 16'($urandom_range(0, 16'h0FFF)); r = 1'b1; w = 1'b1; end
            is_io = (a[15:8] == 8'hFF);
            check_data = 1'b0; exp_data = 8'h00;
            if (r && w)                begin exp_ack = 1'b0; exp_lat = 1; check_data = 1'b1; end
            else if (is_io)            begin exp_ack = 1'b1; exp_lat = io_delay + 1; check_data = r; exp_data = io_val; end
            else if (a < 16'h1000)     begin
                exp_ack = 1'b1; exp_lat = 2 + ram_wait(0);
                if (r && known[0][a[11:0]]) begin check_data = 1'b1; exp_data = mem[0][a[11:0]]; end
            end
            else                       begin exp_ack = 1'b0; exp_lat = 1; check_data = 1'b1; end
            bus_access(0, r, w, a, d, lat, a_, e_, dout, so, sg);
            if (w && !r && a < 16'h1000) begin mem[0][a[11:0]] = d; known[0][a[11:0]] = 1'b1; end
            checks++;
            if ({a_, e_, lat} !== {exp_ack, !exp_ack, exp_lat} || sg !== 1'b1) begin
                errors++; $display("[TB] FAIL rand_resp #%0d addr %h rd=%0b wr=%0b: got ack=%0b err=%0b lat=%0d single=%0b expected ack=%0b lat=%0d",
                                   n, a, r, w, a_, e_, lat, sg, exp_ack, exp_lat);
            end
            if (check_data) begin
                checks++;
                if (dout !== exp_data) begin
                    errors++; $display("[TB] FAIL rand_data #%0d addr %h: got %h expected %h", n, a, dout, exp_data);
                end
            end
            if (is_io && !(r && w)) begin
                checks++;
                if (so !== 1'b1) begin
                    errors++; $display("[TB] FAIL rand_io_strobe #%0d addr %h: got io_addr=%h expected %h", n, a, io_addr[0], a[7:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ram_round_trip();
        test_wait_states();
        test_io_read();
        test_decode_errors();
        test_timeout();
        test_abort();
        test_reset_mid_io();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/o8_memctl.md
# o8_memctl

Bus-side memory controller for the O8 CPU. It terminates the CPU's `rd`/`wr`/`ack`/`err` byte bus and decodes each 16-bit address into one of three regions: on-chip RAM, an external I/O page, or unmapped. It inserts programmable RAM wait states and runs a handshake with the I/O port. It returns exactly one `ack_o` or `err_o` pulse per request. It connects directly to the CPU's `addr_o`/`data_o`/`data_i`/`rd_o`/`wr_o`/`ack_i`/`err_i` pins.

## Interface
- `RAM_AW`, 12: RAM address width. RAM occupies `0x0000`..`2^RAM_AW-1`.
- `RAM_WAIT`, 0: extra wait cycles per RAM access, 0..15.
- `IO_PAGE`, 8'hFF: high address byte that selects the I/O page.
- `TIMEOUT`, 15: I/O cycles to wait for `io_ack_i` before returning an error, 1..255.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `addr_i`  in  16  CPU address.
- `data_i`  in  8  CPU write data.
- `data_o`  out  8  read data; registered; valid while `ack_o`=1.
- `rd_i`  in  1  read request; level, held until ack or err.
- `wr_i`  in  1  write request; level, held until ack or err.
- `ack_o`  out  1  one-cycle success pulse.
- `err_o`  out  1  one-cycle failure pulse.
- `io_addr_o`  out  8  low address byte for the I/O page.
- `io_data_o`  out  8  I/O write data.
- `io_data_i`  in  8  I/O read data; sampled when `io_ack_i`=1.
- `io_rd_o`  out  1  I/O read strobe.
- `io_wr_o`  out  1  I/O write strobe.
- `io_ack_i`  in  1  I/O completion.

## Operation
- **States:** IDLE, RWAIT, IO, RESP.
- **IDLE.** A request (`rd_i|wr_i`) is sampled and decoded:
  - `rd_i&wr_i` → RESP with `err_o`.
  - `addr_i[15:8]==IO_PAGE` → IO. This takes priority over RAM when the regions overlap.
  - `addr_i < 2^RAM_AW` → RWAIT, with the wait counter loaded with `RAM_WAIT`.
  - Any other address → RESP with `err_o`.
- **RWAIT.**
  - The counter decrements each cycle.
  - At 0 the access executes and the FSM goes to RESP with `ack_o`=1.
  - A read loads `data_o` from RAM. A write commits `data_i` to RAM on that same edge.
- **IO.**
  - `io_rd_o`/`io_wr_o` and `io_addr_o` are registered and held until `io_ack_i`.
  - On `io_ack_i`: `data_o`←`io_data_i` for reads, strobes drop, and the FSM goes to RESP with `ack_o`.
- **RESP.**
  - `ack_o` or `err_o` is high for exactly one cycle, then the FSM returns to IDLE.
  - The request still asserted during RESP is treated as consumed and is not re-decoded.
  - The next request is sampled in IDLE on the following edge.
- **`data_o` on error.** `err_o` responses drive `data_o`=0.
- **Request withdrawn.** If `rd_i|wr_i` falls in RWAIT or IO, the FSM aborts to IDLE. There is no RAM commit, strobes drop next edge, and no ack or err is produced.
- **Reset.** Asynchronous. State→IDLE; `ack_o`, `err_o`, `io_rd_o`, `io_wr_o` = 0; `data_o`, `io_addr_o`, `io_data_o` = 0. RAM contents are not cleared.

## Timing
- Request first high at edge E0. RAM response pulse is seen at edge E0+2+`RAM_WAIT` (`RAM_WAIT`=0: 2 cycles).
- Minimum spacing between back-to-back requests is 3 edges with `RAM_WAIT`=0, because RESP is followed by an IDLE sample.
- I/O strobe is visible after E0+1. The response pulse comes the cycle after the edge that samples `io_ack_i`.
- Decode errors pulse at E0+1.
- `ack_o` and `err_o` are never high together.

## Configuration
- `O8_MEMCTL_TIMEOUT_EN`
  - **Defined:** an 8-bit counter loads `TIMEOUT` on IO entry and decrements each IO cycle. If it reaches 0 without `io_ack_i`, strobes drop and the FSM goes to RESP with `err_o`. `io_ack_i` on the same edge wins.
  - **Undefined:** the counter is not built and IO waits for `io_ack_i` indefinitely.

## Test plan
- **RAM round trip:** `RAM_WAIT`=0; write `0x5A` to `0x0123`, then read `0x0123` → `ack_o` 2 edges after each request; the read returns `data_o`=`0x5A`.
- **Wait states:** `RAM_WAIT`=3; read `0x0000` → `ack_o` exactly 5 edges after the request; no pulse earlier.
- **I/O read:** read `0xFF10`; responder raises `io_ack_i` 4 cycles after `io_rd_o` with `0xC3` → `io_addr_o`=`0x10`, `ack_o`, `data_o`=`0xC3`.
- **Decode errors:** read `0x2000` (`RAM_AW`=12) → `err_o` pulse, `data_o`=0. `rd_i`=`wr_i`=1 at `0x0000` → `err_o` and RAM unchanged.
- **Timeout:** with `O8_MEMCTL_TIMEOUT_EN`, `TIMEOUT`=15; write `0xFF00` and never ack → `err_o` after 15 IO cycles, `io_wr_o` low afterwards.
- **Abort and reset:** `RAM_WAIT`=5 write, drop `wr_i` at cycle 2 → no ack and RAM unchanged. Pull `rst_ni` low mid-IO → strobes and `ack_o` go 0 asynchronously; state is IDLE after release.
